maze_port_arbiter: RTL and testbench

//  Shares the single-port maze tile RAM among NUM_REQ requesters: port 0 = VGA tile renderer,

---
 rtl/maze_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/maze_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_maze_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared maze definitions: playfield size, tile codes and {y,x} RAM address packing.
package maze_pkg;

   localparam int unsigned MAZE_W = 28;
   localparam int unsigned MAZE_H = 31;
   localparam int unsigned TILE_W = 2;
   localparam int unsigned X_W    = 6;
   localparam int unsigned Y_W    = 5;
   localparam int unsigned ADDR_W = X_W + Y_W;

   typedef enum logic [TILE_W-1:0] {
      TileEmpty  = 2'd0,
      TilePellet = 2'd1,
      TilePower  = 2'd2,
      TileWall   = 2'd3
   } tile_e;

   function automatic logic [ADDR_W-1:0] pack_addr(input logic [Y_W-1:0] y,
                                                   input logic [X_W-1:0] x);
      return {y, x};
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick over ports 1..NUM_REQ-1, starting the search at rr_ptr and wrapping.
// Port 0 is never considered here; the top applies its priority separately.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
   output logic [NUM_REQ-1:0]         gnt,
   output logic                       found
);

   localparam int unsigned PW = $clog2(NUM_REQ);

   // First requester at or cyclically after rr_ptr wins
   always_comb begin
      int unsigned idx;
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      for (int unsigned off = 0; off < NUM_REQ - 1; off++) begin
         idx = ((32'(rr_ptr) - 1 + off) % (NUM_REQ - 1)) + 1;
         if (!found && req[idx[PW-1:0]]) begin
            gnt[idx[PW-1:0]] = 1'b1;
            found            = 1'b1;
         end
      end
   end

endmodule

// File: rtl/maze_port_arbiter.sv
// Maze tile RAM port arbiter: port 0 (renderer) has priority bounded by a starvation guard,
// ports 1..NUM_REQ-1 (game logic) share round-robin. One access issued per cycle; read data
// is routed back to the issuer after 1+RD_LAT cycles.
// Optional build macro MAZE_ARB_STATS_EN adds a saturating stall-cycle counter output.
module maze_port_arbiter
   import maze_pkg::*;
#(
   parameter int unsigned       NUM_REQ  = 4,
   parameter int unsigned       TILE_W   = maze_pkg::TILE_W,
   parameter int unsigned       MAZE_W   = maze_pkg::MAZE_W,
   parameter int unsigned       MAZE_H   = maze_pkg::MAZE_H,
   parameter int unsigned       RD_LAT   = 1,
   parameter int unsigned       MAX_WAIT = 8,
   parameter logic [TILE_W-1:0] OOB_TILE = TileWall
) (
   input  logic                  clk_100mhz,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ-1:0]    req_we,
   input  logic [NUM_REQ*6-1:0]  req_x,
   input  logic [NUM_REQ*5-1:0]  req_y,
   input  logic [NUM_REQ*TILE_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]    gnt,
   output logic [NUM_REQ-1:0]    rvalid,
   output logic [TILE_W-1:0]     rdata,
   output logic [10:0]           mem_addr,
   output logic                  mem_we,
   output logic [TILE_W-1:0]     mem_wdata,
   input  logic [TILE_W-1:0]     mem_rdata
`ifdef MAZE_ARB_STATS_EN
   ,
   output logic [15:0]           stat_stall_cnt
`endif
);

   localparam int unsigned PW = $clog2(NUM_REQ);
   localparam int unsigned WW = $clog2(MAX_WAIT + 1);

   logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [WW-1:0]      wait_cnt_q, wait_cnt_d;
   logic [NUM_REQ-1:0] rr_gnt;
   logic               rr_found;
   logic               game_req;
   logic               gnt_any;
   logic               gnt_game;
   logic [PW-1:0]      gnt_idx;
   logic [5:0]         sel_x;
   logic [4:0]         sel_y;
   logic               sel_we;
   logic [TILE_W-1:0]  sel_wdata;
   logic               sel_in_range;

   // Return pipeline: stages 0..RD_LAT-1 track (valid, id, oob); rvalid/rdata form the last stage
   logic [RD_LAT-1:0]  pipe_vld_q;
   logic [RD_LAT-1:0]  pipe_oob_q;
   logic [PW-1:0]      pipe_id_q [RD_LAT];

   rr_arbiter #(
      .NUM_REQ(NUM_REQ)
   ) u_rr_arbiter (
      .req   (req),
      .rr_ptr(rr_ptr_q),
      .gnt   (rr_gnt),
      .found (rr_found)
   );

   // Grant: port 0 unless its guard expired; then round-robin; port 0 again if nobody else
   always_comb begin
      game_req = |req[NUM_REQ-1:1];
      gnt      = '0;
      if (req[0] && (wait_cnt_q < WW'(MAX_WAIT))) begin
         gnt[0] = 1'b1;
      end else if (rr_found) begin
         gnt = rr_gnt;
      end else if (req[0]) begin
         gnt[0] = 1'b1;
      end
   end

   // Encode the one-hot grant and select the granted request's fields
   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) gnt_idx = PW'(i);
      end
      gnt_any      = |gnt;
      gnt_game     = gnt_any && (gnt_idx != '0);
      sel_x        = req_x[6*32'(gnt_idx) +: 6];
      sel_y        = req_y[5*32'(gnt_idx) +: 5];
      sel_we       = req_we[gnt_idx];
      sel_wdata    = req_wdata[TILE_W*32'(gnt_idx) +: TILE_W];
      sel_in_range = (32'(sel_x) < MAZE_W) && (32'(sel_y) < MAZE_H);
   end

   // Round-robin pointer and starvation counter next state
   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      wait_cnt_d = wait_cnt_q;
      if (gnt_game) begin
         rr_ptr_d = (32'(gnt_idx) == NUM_REQ - 1) ? PW'(1) : gnt_idx + PW'(1);
      end
      if (gnt_game || !game_req) begin
         wait_cnt_d = '0;
      end else if (wait_cnt_q < WW'(MAX_WAIT)) begin
         wait_cnt_d = wait_cnt_q + WW'(1);
      end
   end

   // Arbitration state
   always_ff @(posedge clk_100mhz or posedge rst) begin
      if (rst) begin
         rr_ptr_q   <= PW'(1);
         wait_cnt_q <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Issue the granted access; out-of-range writes are suppressed at the RAM
   always_ff @(posedge clk_100mhz or posedge rst) begin
      if (rst) begin
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
      end else if (gnt_any) begin
         mem_addr  <= pack_addr(sel_y, sel_x);
         mem_we    <= sel_we && sel_in_range;
         mem_wdata <= sel_wdata;
      end else begin
         mem_we    <= 1'b0;
      end
   end

   // Read return tracking; reset discards anything in flight
   always_ff @(posedge clk_100mhz or posedge rst) begin
      if (rst) begin
         pipe_vld_q <= '0;
         pipe_oob_q <= '0;
         for (int i = 0; i < RD_LAT; i++) pipe_id_q[i] <= '0;
         rvalid     <= '0;
         rdata      <= '0;
      end else begin
         pipe_vld_q[0] <= gnt_any && !sel_we;
         pipe_oob_q[0] <= !sel_in_range;
         pipe_id_q[0]  <= gnt_idx;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld_q[i] <= pipe_vld_q[i-1];
            pipe_oob_q[i] <= pipe_oob_q[i-1];
            pipe_id_q[i]  <= pipe_id_q[i-1];
         end
         rvalid <= pipe_vld_q[RD_LAT-1] ? (NUM_REQ'(1) << pipe_id_q[RD_LAT-1]) : '0;
         if (pipe_vld_q[RD_LAT-1]) begin
            rdata <= pipe_oob_q[RD_LAT-1] ? OOB_TILE : mem_rdata;
         end
      end
   end

`ifdef MAZE_ARB_STATS_EN
   // Count cycles in which any requester is left waiting
   always_ff @(posedge clk_100mhz or posedge rst) begin
      if (rst) begin
         stat_stall_cnt <= '0;
      end else if (((req & ~gnt) != '0) && (stat_stall_cnt != 16'hFFFF)) begin
         stat_stall_cnt <= stat_stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_maze_port_arbiter.sv
// Bench for maze_port_arbiter: directed scenarios followed by random traffic, all checked
// against a transaction-level model (grant rules, a tile array and a queue of due reads).
module tb_maze_port_arbiter;

   localparam int NUM_REQ  = 4;
   localparam int RD_LAT   = 1;
   localparam int MAX_WAIT = 8;

   logic                   clk_100mhz = 1'b0;
   logic                   rst;
   logic [NUM_REQ-1:0]     req;
   logic [NUM_REQ-1:0]     req_we;
   logic [NUM_REQ*6-1:0]   req_x;
   logic [NUM_REQ*5-1:0]   req_y;
   logic [NUM_REQ*2-1:0]   req_wdata;
   logic [NUM_REQ-1:0]     gnt;
   logic [NUM_REQ-1:0]     rvalid;
   logic [1:0]             rdata;
   logic [10:0]            mem_addr;
   logic                   mem_we;
   logic [1:0]             mem_wdata;
   logic [1:0]             mem_rdata;

   maze_port_arbiter dut (
      .clk_100mhz(clk_100mhz),
      .rst       (rst),
      .req       (req),
      .req_we    (req_we),
      .req_x     (req_x),
      .req_y     (req_y),
      .req_wdata (req_wdata),
      .gnt       (gnt),
      .rvalid    (rvalid),
      .rdata     (rdata),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk_100mhz = ~clk_100mhz;

   function automatic logic [1:0] init_tile(input int a);
      return 2'((a * 13 + (a >> 4)) % 4);
   endfunction

   // RAM environment: asynchronous read of mem_addr (RD_LAT=1), write on the clock edge
   logic [1:0] ram      [2048];
   bit         wr_valid [2048];
   assign mem_rdata = wr_valid[mem_addr] ? ram[mem_addr] : init_tile(int'(mem_addr));
   always @(posedge clk_100mhz) begin
      if (mem_we) begin
         ram[mem_addr]      <= mem_wdata;
         wr_valid[mem_addr] <= 1'b1;
      end
   end

   // Requester state
   bit   p_req [NUM_REQ];
   bit   p_we  [NUM_REQ];
   int   p_x   [NUM_REQ];
   int   p_y   [NUM_REQ];
   int   p_wd  [NUM_REQ];

   // Reference model state
   typedef struct {
      int         due;
      int         port;
      logic [1:0] data;
   } rd_t;
   rd_t        pend[$];
   logic [1:0] exp_ram [2048];
   int         m_wait, m_rr;
   int         e_addr, e_wdata;
   bit         e_we;
   int         cyc;
   int         last_g;
   int         n_cmp, n_mis;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic drive();
      for (int p = 0; p < NUM_REQ; p++) begin
         req[p]            = p_req[p];
         req_we[p]         = p_we[p];
         req_x[6*p +: 6]   = 6'(p_x[p]);
         req_y[5*p +: 5]   = 5'(p_y[p]);
         req_wdata[2*p +: 2] = 2'(p_wd[p]);
      end
   endtask

   task automatic set_req(input int p, input bit we, input int x, input int y, input int wd);
      p_req[p] = 1'b1;
      p_we[p]  = we;
      p_x[p]   = x;
      p_y[p]   = y;
      p_wd[p]  = wd;
   endtask

   task automatic rand_req(input int p);
      set_req(p, ($urandom_range(0, 99) < 30), int'($urandom_range(24, 31)),
              int'($urandom_range(26, 31)), int'($urandom_range(0, 3)));
   endtask

   task automatic model_reset();
      pend.delete();
      m_wait  = 0;
      m_rr    = 1;
      e_addr  = 0;
      e_we    = 1'b0;
      e_wdata = 0;
   endtask

   // One clock cycle: drive, sample mid-cycle, compare, advance the model, cross the edge
   task automatic step();
      int               g;
      bit               any_game;
      logic [NUM_REQ-1:0] eg, erv;
      logic [1:0]       erd;
      drive();
      #4;
      any_game = 1'b0;
      for (int c = 1; c < NUM_REQ; c++) any_game |= p_req[c];
      g = -1;
      if (p_req[0] && m_wait < MAX_WAIT) begin
         g = 0;
      end else begin
         int best;
         best = NUM_REQ;
         for (int c = 1; c < NUM_REQ; c++) begin
            if (p_req[c]) begin
               int d;
               d = (c - m_rr + (NUM_REQ - 1)) % (NUM_REQ - 1);
               if (d < best) begin
                  best = d;
                  g    = c;
               end
            end
         end
         if (g < 0 && p_req[0]) g = 0;
      end
      eg = '0;
      if (g >= 0) eg[g] = 1'b1;
      erv = '0;
      erd = 2'b00;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         erv[pend[0].port] = 1'b1;
         erd = pend[0].data;
         void'(pend.pop_front());
      end
      check("gnt", 32'(gnt), 32'(eg));
      check("rvalid", 32'(rvalid), 32'(erv));
      if (erv != '0) check("rdata", 32'(rdata), 32'(erd));
      check("mem_we", 32'(mem_we), 32'(e_we));
      check("mem_addr", 32'(mem_addr), 32'(e_addr));
      if (e_we) check("mem_wdata", 32'(mem_wdata), 32'(e_wdata));

      if (g >= 0) begin
         bit inr;
         int a;
         inr     = (p_x[g] < 28) && (p_y[g] < 31);
         a       = p_y[g] * 64 + p_x[g];
         e_addr  = a;
         e_we    = p_we[g] && inr;
         e_wdata = p_wd[g];
         if (!p_we[g]) begin
            rd_t r;
            r.due  = cyc + 1 + RD_LAT;
            r.port = g;
            r.data = inr ? exp_ram[a] : 2'b11;
            pend.push_back(r);
         end else if (inr) begin
            exp_ram[a] = 2'(p_wd[g]);
         end
      end else begin
         e_we = 1'b0;
      end
      if (g >= 1) m_rr = (g == NUM_REQ - 1) ? 1 : g + 1;
      if (g >= 1 || !any_game) m_wait = 0;
      else if (m_wait < MAX_WAIT) m_wait++;
      last_g = g;
      cyc++;
      @(posedge clk_100mhz);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_gnt"}, 32'(gnt), 32'd0);
      check({tag, "_rvalid"}, 32'(rvalid), 32'd0);
      check({tag, "_rdata"}, 32'(rdata), 32'd0);
      check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
      check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
      check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
   endtask

   initial begin
      n_cmp = 0;
      n_mis = 0;
      cyc   = 0;
      for (int a = 0; a < 2048; a++) exp_ram[a] = init_tile(a);
      for (int p = 0; p < NUM_REQ; p++) begin
         p_req[p] = 1'b0; p_we[p] = 1'b0; p_x[p] = 0; p_y[p] = 0; p_wd[p] = 0;
      end
      model_reset();
      rst = 1'b1;
      drive();
      repeat (2) @(posedge clk_100mhz);
      #3;
      check_idle_outputs("reset");
      @(posedge clk_100mhz);
      #1;
      rst = 1'b0;

      // Port 1 stores PELLET at x=9,y=17, then reads it back
      set_req(1, 1'b1, 9, 17, 1);
      step();
      p_req[1] = 1'b0;
      set_req(1, 1'b0, 9, 17, 0);
      step();
      p_req[1] = 1'b0;
      check("t1_addr", 32'(mem_addr), 32'h449);  // {y=17, x=9}
      repeat (3) step();

      // Three game ports held continuously: strict rotation
      set_req(1, 1'b0, 1, 1, 0);
      set_req(2, 1'b0, 2, 2, 0);
      set_req(3, 1'b0, 3, 3, 0);
      repeat (9) step();
      p_req[1] = 1'b0; p_req[3] = 1'b0;

      // Port 0 held against port 2: guard forces port 2 through after MAX_WAIT losses
      set_req(0, 1'b0, 0, 0, 0);
      set_req(2, 1'b0, 4, 4, 0);
      repeat (12) step();
      p_req[2] = 1'b0;
      step();
      p_req[0] = 1'b0;
      repeat (3) step();

      // Write EMPTY then immediately read the same cell
      set_req(1, 1'b1, 9, 17, 0);
      step();
      set_req(1, 1'b0, 9, 17, 0);
      step();
      p_req[1] = 1'b0;
      repeat (3) step();

      // Out-of-range read and write from port 3
      set_req(3, 1'b0, 30, 5, 0);
      step();
      set_req(3, 1'b1, 5, 31, 1);
      step();
      p_req[3] = 1'b0;
      repeat (3) step();

      // Reset with reads in flight
      set_req(1, 1'b0, 2, 3, 0);
      step();
      p_req[1] = 1'b0;
      set_req(2, 1'b0, 4, 5, 0);
      step();
      p_req[2] = 1'b0;
      drive();
      rst = 1'b1;
      #2;
      check_idle_outputs("midreset");
      @(posedge clk_100mhz);
      #1;
      rst = 1'b0;
      model_reset();
      repeat (3) step();
      set_req(1, 1'b0, 6, 6, 0);
      set_req(2, 1'b0, 7, 7, 0);
      set_req(3, 1'b0, 8, 8, 0);
      step();
      check("post_reset_first", 32'(last_g), 32'd1);
      for (int p = 0; p < NUM_REQ; p++) p_req[p] = 1'b0;
      repeat (3) step();

      // Random traffic around the playfield edges
      for (int n = 0; n < 1500; n++) begin
         for (int p = 0; p < NUM_REQ; p++) begin
            if (!p_req[p] && $urandom_range(0, 99) < ((p == 0) ? 70 : 35)) rand_req(p);
         end
         step();
         if (last_g >= 0) begin
            p_req[last_g] = 1'b0;
            if ($urandom_range(0, 1) == 1) rand_req(last_g);
         end
      end
      for (int p = 0; p < NUM_REQ; p++) p_req[p] = 1'b0;
      repeat (4) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
